vdc_htiming: RTL and testbench
==============================

# vdc_htiming

Parametrised horizontal timing generator for the VDC display pipeline. It derives pixel and column counters, visible-column window, display enable, horizontal sync and horizontal blanking from the R0–R35 horizontal register set. It replaces the fixed-width horizontal signal block and adds three things: configurable counter widths, internally generated sync start, and an optional line-synchronous register shadow. It feeds the character fetch/shift logic and the video output stage.

## Interface
- COL_BITS, 8, column counter / column register width
- PIX_BITS, 5, pixel counter width; reg_cth width is PIX_BITS-1
- SYNC_BITS, 4, sync width register / counter width
- VIS_START, 8, first visible column
- HB_FRONT_PORCH, 2, columns between blank start and sync position
- HB_WIDTH, 18, hblank length in columns (single-width mode)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  pixel-clock enable; all state advances only when high
- reg_ht  in  COL_BITS  R0 horizontal total minus 1
- reg_hd  in  COL_BITS  R1 horizontal displayed
- reg_hp  in  COL_BITS  R2 sync position
- reg_hw  in  SYNC_BITS  R3 sync width in columns
- reg_cth  in  PIX_BITS-1  R22[7:4] character total minus 1
- reg_atr  in  1  R25[6] attribute enable
- reg_dbl  in  1  R25[4] double pixel width
- reg_ai  in  COL_BITS  R27 address increment
- reg_deb  in  COL_BITS  R34 display enable begin
- reg_dee  in  COL_BITS  R35 display enable end
- newCol  out  1  high while pixel holds its first value of a column
- endCol  out  1  high while pixel == reg_cth
- lineStart  out  1  one-enable pulse on first pixel of column 0
- col  out  COL_BITS  current column
- pixel  out  PIX_BITS  current pixel in column
- hVisible  out  1  visible column AND hdispen
- hdispen  out  1  horizontal display enable
- hsync  out  1  horizontal sync
- hblank  out  1  horizontal blank

## Operation
- All outputs registered. Reset value: col=0, pixel=0, all 1-bit outputs 0, internal counters 0.
- Pixel: on enable, if pixel==reg_cth the column ends. The next pixel is {0,reg_dbl}, so a double-width column is one enable shorter. Otherwise pixel+1.
- Column end: col <= (col>=reg_ht) ? 0 : col+1. Out-of-range col after a register write wraps to 0 in one column.
- Boundary events are evaluated on the current col at column end and take effect with the new column:
  - hviscol set when col==VIS_START.
  - hviscol cleared when col==reg_hd+VIS_START, minus 1 if reg_ai!=0 && !reg_atr.
  - hdispen set when col==reg_deb+1, or when reg_deb>reg_ht.
  - hdispen cleared when col==reg_dee+1. If set and clear coincide, clear wins.
  - Sync: when col==reg_hp, the sync counter loads reg_hw; otherwise it decrements if nonzero. hsync = counter!=0, so hsync lasts reg_hw columns. reg_hw=0 produces no sync. A reload while active restarts the count.
  - Blank: when col==(reg_hp>HB_FRONT_PORCH ? reg_hp-HB_FRONT_PORCH-1 : reg_ht-HB_FRONT_PORCH), the blank counter loads HB_WIDTH>>reg_dbl; otherwise it decrements if nonzero. hblank = counter!=0.
- Comparison arithmetic is done at COL_BITS+1 bits. Sums never wrap, so a target beyond reg_ht never matches.
- lineStart is asserted on the transition to col 0.

## Timing
- Line length = (reg_ht+1)·(reg_cth+1) enables, or (reg_ht+1)·reg_cth when reg_dbl=1.
- newCol/endCol/lineStart are level outputs aligned with pixel. They hold while enable is low, so consumers qualify them with enable.
- Counter-driven outputs change one clk after the enabled column-end cycle.
- Asynchronous reset mid-line returns all state to reset values immediately. Counting resumes at col 0, pixel 0 on the first enable after release.
- enable low freezes all state, including sync and blank counters.

## Configuration
- VDC_REG_SHADOW_EN defined: all reg_* inputs are copied into shadow registers on the enabled cycle that wraps col to 0, and the counters use only the shadows.
  - Reset clears the shadows, so reg_ht is 0 and the first column wraps. Shadows therefore load at the end of column 0 after reset.
  - Mid-line register writes take effect from the next line.
- Not defined: reg_* are used live, and a write affects the next column boundary.

## Test plan
- ht=126, cth=7, dbl=0, enable=1: col wraps 126→0 every 1016 clk; endCol high when pixel==7; lineStart one pulse per 1016 clk.
- hp=102, hw=9, FP=2: hsync rises entering col 103 and stays high 9 columns (72 enables); hblank rises entering col 100 and lasts 18 columns. With dbl=1, hblank lasts 9 columns.
- hd=80, ai=0, deb=125, dee=100: hVisible high for cols 9..88 inclusive; with ai=1, atr=0 it ends one column earlier.
- reg_deb=200 > ht=126: hdispen set at the first column boundary; dee match clears it, and the next boundary sets it again.
- Write reg_ht=60 while col=100: live build wraps to 0 at the next column end. With VDC_REG_SHADOW_EN, the line completes at 126 and the following line wraps at 60.
- Assert reset at col=50, pixel=3, then release: all outputs 0; first enable yields pixel=1, col=0.

Source files
------------

// File: rtl/vdc_htiming.sv
// rtl/vdc_htiming.sv - VDC horizontal timing generator (column/pixel counters, display enable, sync, blank)
// Optional line-synchronous register shadow: define VDC_REG_SHADOW_EN.
module vdc_htiming #(
   parameter int COL_BITS       = 8,
   parameter int PIX_BITS       = 5,
   parameter int SYNC_BITS      = 4,
   parameter int VIS_START      = 8,
   parameter int HB_FRONT_PORCH = 2,
   parameter int HB_WIDTH       = 18
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [COL_BITS-1:0]  reg_ht,
   input  logic [COL_BITS-1:0]  reg_hd,
   input  logic [COL_BITS-1:0]  reg_hp,
   input  logic [SYNC_BITS-1:0] reg_hw,
   input  logic [PIX_BITS-2:0]  reg_cth,
   input  logic                reg_atr,
   input  logic                reg_dbl,
   input  logic [COL_BITS-1:0]  reg_ai,
   input  logic [COL_BITS-1:0]  reg_deb,
   input  logic [COL_BITS-1:0]  reg_dee,
   output logic                newCol,
   output logic                endCol,
   output logic                lineStart,
   output logic [COL_BITS-1:0]  col,
   output logic [PIX_BITS-1:0]  pixel,
   output logic                hVisible,
   output logic                hdispen,
   output logic                hsync,
   output logic                hblank
);
   localparam int CW = COL_BITS + 1;

   logic [COL_BITS-1:0]  w_ht, w_hd, w_hp, w_ai, w_deb, w_dee;
   logic [SYNC_BITS-1:0] w_hw;
   logic [PIX_BITS-2:0]  w_cth;
   logic                 w_atr, w_dbl;

   logic [COL_BITS-1:0]  r_col;
   logic [PIX_BITS-1:0]  r_pixel;
   logic                 r_newcol, r_endcol, r_linestart;
   logic                 r_hviscol, r_hdispen, r_hvisible, r_hsync, r_hblank;
   logic [SYNC_BITS-1:0] r_sync_cnt;
   logic [COL_BITS-1:0]  r_blank_cnt;

   logic                 w_col_end, w_wrap, w_vis_trim;
   logic [COL_BITS-1:0]  w_col_next, w_hb_len;
   logic [PIX_BITS-1:0]  w_pix_next;
   logic [CW-1:0]        w_col_x, w_vis_end, w_deb_tgt, w_dee_tgt, w_hb_tgt;
   logic                 w_vis_next, w_den_next;
   logic [SYNC_BITS-1:0] w_sync_next;
   logic [COL_BITS-1:0]  w_blank_next;

`ifdef VDC_REG_SHADOW_EN
   logic [COL_BITS-1:0]  r_ht, r_hd, r_hp, r_ai, r_deb, r_dee;
   logic [SYNC_BITS-1:0] r_hw;
   logic [PIX_BITS-2:0]  r_cth;
   logic                 r_atr, r_dbl;

   // Shadows load on the enabled cycle that wraps col to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ht  <= '0;
         r_hd  <= '0;
         r_hp  <= '0;
         r_hw  <= '0;
         r_cth <= '0;
         r_atr <= 1'b0;
         r_dbl <= 1'b0;
         r_ai  <= '0;
         r_deb <= '0;
         r_dee <= '0;
      end else if (enable && w_col_end && w_wrap) begin
         r_ht  <= reg_ht;
         r_hd  <= reg_hd;
         r_hp  <= reg_hp;
         r_hw  <= reg_hw;
         r_cth <= reg_cth;
         r_atr <= reg_atr;
         r_dbl <= reg_dbl;
         r_ai  <= reg_ai;
         r_deb <= reg_deb;
         r_dee <= reg_dee;
      end
   end

   assign w_ht  = r_ht;
   assign w_hd  = r_hd;
   assign w_hp  = r_hp;
   assign w_hw  = r_hw;
   assign w_cth = r_cth;
   assign w_atr = r_atr;
   assign w_dbl = r_dbl;
   assign w_ai  = r_ai;
   assign w_deb = r_deb;
   assign w_dee = r_dee;
`else
   assign w_ht  = reg_ht;
   assign w_hd  = reg_hd;
   assign w_hp  = reg_hp;
   assign w_hw  = reg_hw;
   assign w_cth = reg_cth;
   assign w_atr = reg_atr;
   assign w_dbl = reg_dbl;
   assign w_ai  = reg_ai;
   assign w_deb = reg_deb;
   assign w_dee = reg_dee;
`endif

   assign w_col_end  = (r_pixel == {1'b0, w_cth});
   assign w_wrap     = (r_col >= w_ht);
   assign w_col_next = w_wrap ? '0 : r_col + 1'b1;
   assign w_pix_next = w_col_end ? {{(PIX_BITS-1){1'b0}}, w_dbl} : r_pixel + 1'b1;

   // Targets are widened by one bit so a sum past the column range never matches.
   assign w_col_x    = {1'b0, r_col};
   assign w_vis_trim = (w_ai != '0) && !w_atr;
   assign w_vis_end  = {1'b0, w_hd} + CW'(VIS_START) - {{COL_BITS{1'b0}}, w_vis_trim};
   assign w_deb_tgt  = {1'b0, w_deb} + CW'(1);
   assign w_dee_tgt  = {1'b0, w_dee} + CW'(1);
   assign w_hb_tgt   = ({1'b0, w_hp} > CW'(HB_FRONT_PORCH))
                       ? {1'b0, w_hp} - CW'(HB_FRONT_PORCH + 1)
                       : {1'b0, w_ht} - CW'(HB_FRONT_PORCH);
   assign w_hb_len   = w_dbl ? COL_BITS'(HB_WIDTH >> 1) : COL_BITS'(HB_WIDTH);

   always_comb begin
      w_vis_next   = r_hviscol;
      w_den_next   = r_hdispen;
      w_sync_next  = r_sync_cnt;
      w_blank_next = r_blank_cnt;
      if (w_col_end) begin
         if (w_col_x == CW'(VIS_START)) w_vis_next = 1'b1;
         if (w_col_x == w_vis_end)      w_vis_next = 1'b0;
         if ((w_col_x == w_deb_tgt) || (w_deb > w_ht)) w_den_next = 1'b1;
         if (w_col_x == w_dee_tgt)      w_den_next = 1'b0;
         if (r_col == w_hp)              w_sync_next = w_hw;
         else if (r_sync_cnt != '0)      w_sync_next = r_sync_cnt - 1'b1;
         if (w_col_x == w_hb_tgt)        w_blank_next = w_hb_len;
         else if (r_blank_cnt != '0)     w_blank_next = r_blank_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col       <= '0;
         r_pixel     <= '0;
         r_newcol    <= 1'b0;
         r_endcol    <= 1'b0;
         r_linestart <= 1'b0;
         r_hviscol   <= 1'b0;
         r_hdispen   <= 1'b0;
         r_hvisible  <= 1'b0;
         r_hsync     <= 1'b0;
         r_hblank    <= 1'b0;
         r_sync_cnt  <= '0;
         r_blank_cnt <= '0;
      end else if (enable) begin
         r_pixel     <= w_pix_next;
         r_newcol    <= w_col_end;
         r_endcol    <= (w_pix_next == {1'b0, w_cth});
         r_linestart <= w_col_end && w_wrap;
         if (w_col_end) r_col <= w_col_next;
         r_hviscol   <= w_vis_next;
         r_hdispen   <= w_den_next;
         r_hvisible  <= w_vis_next && w_den_next;
         r_sync_cnt  <= w_sync_next;
         r_blank_cnt <= w_blank_next;
         r_hsync     <= (w_sync_next != '0);
         r_hblank    <= (w_blank_next != '0);
      end
   end

   assign col       = r_col;
   assign pixel     = r_pixel;
   assign newCol    = r_newcol;
   assign endCol    = r_endcol;
   assign lineStart = r_linestart;
   assign hVisible  = r_hvisible;
   assign hdispen   = r_hdispen;
   assign hsync     = r_hsync;
   assign hblank    = r_hblank;
endmodule

// File: tb/tb_vdc_htiming.sv
// tb/tb_vdc_htiming.sv - scoreboard bench for vdc_htiming (live or VDC_REG_SHADOW_EN build)
module tb_vdc_htiming;
   localparam int VIS = 8;
   localparam int FP  = 2;
   localparam int HBW = 18;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [7:0] reg_ht, reg_hd, reg_hp, reg_ai, reg_deb, reg_dee;
   logic [3:0] reg_hw, reg_cth;
   logic       reg_atr, reg_dbl;
   logic       newCol, endCol, lineStart, hVisible, hdispen, hsync, hblank;
   logic [7:0] col;
   logic [4:0] pixel;

   always #5 clk = ~clk;

   vdc_htiming dut (
      .clk(clk), .reset(reset), .enable(enable),
      .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hp(reg_hp), .reg_hw(reg_hw),
      .reg_cth(reg_cth), .reg_atr(reg_atr), .reg_dbl(reg_dbl), .reg_ai(reg_ai),
      .reg_deb(reg_deb), .reg_dee(reg_dee),
      .newCol(newCol), .endCol(endCol), .lineStart(lineStart), .col(col),
      .pixel(pixel), .hVisible(hVisible), .hdispen(hdispen), .hsync(hsync),
      .hblank(hblank)
   );

   typedef struct packed {
      logic [7:0] col;
      logic [4:0] pix;
      logic nc, ec, ls, vis, den, hs, hb;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state
   int m_col, m_pix, m_vis, m_den, m_sync, m_blank, m_nc, m_ec, m_ls;
   int s_ht, s_hd, s_hp, s_hw, s_cth, s_atr, s_dbl, s_ai, s_deb, s_dee;
   int c_ht, c_hd, c_hp, c_hw, c_cth, c_atr, c_dbl, c_ai, c_deb, c_dee;

   // Line statistics taken from DUT outputs, counted in enables
   int en_cnt = 0, ls_seen = 0, ls_prev = 0, ls_last = 0;
   int cnt_hs = 0, cnt_hb = 0, cnt_vis = 0, cnt_den = 0;
   int last_hs = 0, last_hb = 0, last_vis = 0, last_den = 0;
   int prev_col = 0, wrap_col = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_col = 0; m_pix = 0; m_vis = 0; m_den = 0; m_sync = 0; m_blank = 0;
      m_nc = 0; m_ec = 0; m_ls = 0;
      s_ht = 0; s_hd = 0; s_hp = 0; s_hw = 0; s_cth = 0;
      s_atr = 0; s_dbl = 0; s_ai = 0; s_deb = 0; s_dee = 0;
   endtask

   task automatic shadow_load();
      s_ht = int'(reg_ht); s_hd = int'(reg_hd); s_hp = int'(reg_hp); s_hw = int'(reg_hw);
      s_cth = int'(reg_cth); s_atr = int'(reg_atr); s_dbl = int'(reg_dbl);
      s_ai = int'(reg_ai); s_deb = int'(reg_deb); s_dee = int'(reg_dee);
   endtask

   task automatic get_cur();
`ifdef VDC_REG_SHADOW_EN
      c_ht = s_ht; c_hd = s_hd; c_hp = s_hp; c_hw = s_hw; c_cth = s_cth;
      c_atr = s_atr; c_dbl = s_dbl; c_ai = s_ai; c_deb = s_deb; c_dee = s_dee;
`else
      c_ht = int'(reg_ht); c_hd = int'(reg_hd); c_hp = int'(reg_hp); c_hw = int'(reg_hw);
      c_cth = int'(reg_cth); c_atr = int'(reg_atr); c_dbl = int'(reg_dbl);
      c_ai = int'(reg_ai); c_deb = int'(reg_deb); c_dee = int'(reg_dee);
`endif
   endtask

   task automatic model_step();
      int nc, hbt;
      get_cur();
      if (m_pix == c_cth) begin
         nc = (m_col >= c_ht) ? 0 : m_col + 1;
         if (m_col == VIS) m_vis = 1;
         if (m_col == c_hd + VIS - ((c_ai != 0 && c_atr == 0) ? 1 : 0)) m_vis = 0;
         if (m_col == c_deb + 1 || c_deb > c_ht) m_den = 1;
         if (m_col == c_dee + 1) m_den = 0;
         if (m_col == c_hp) m_sync = c_hw;
         else if (m_sync > 0) m_sync--;
         hbt = (c_hp > FP) ? c_hp - FP - 1 : c_ht - FP;
         if (m_col == hbt) m_blank = c_dbl ? HBW / 2 : HBW;
         else if (m_blank > 0) m_blank--;
         m_nc = 1; m_ls = (nc == 0); m_col = nc; m_pix = c_dbl;
`ifdef VDC_REG_SHADOW_EN
         if (nc == 0) shadow_load();
`endif
      end else begin
         m_pix++; m_nc = 0; m_ls = 0;
      end
      m_ec = (m_pix == c_cth);
   endtask

   function automatic obs_t model_obs();
      return '{col: 8'(m_col), pix: 5'(m_pix), nc: 1'(m_nc), ec: 1'(m_ec), ls: 1'(m_ls),
               vis: 1'(m_vis & m_den), den: 1'(m_den), hs: (m_sync != 0), hb: (m_blank != 0)};
   endfunction

   function automatic obs_t dut_obs();
      return '{col: col, pix: pixel, nc: newCol, ec: endCol, ls: lineStart,
               vis: hVisible, den: hdispen, hs: hsync, hb: hblank};
   endfunction

   task automatic cycle(input logic en);
      obs_t e;
      enable = en;
      if (en) model_step();
      exp_q.push_back(model_obs());
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("obs@en%0d", en_cnt), 32'(dut_obs()), 32'(e));
      if (en) begin
         en_cnt++;
         if (lineStart) begin
            last_hs = cnt_hs; last_hb = cnt_hb; last_vis = cnt_vis; last_den = cnt_den;
            cnt_hs = 0; cnt_hb = 0; cnt_vis = 0; cnt_den = 0;
            ls_prev = ls_last; ls_last = en_cnt; ls_seen++;
            wrap_col = prev_col;
         end
         cnt_hs += int'(hsync); cnt_hb += int'(hblank);
         cnt_vis += int'(hVisible); cnt_den += int'(hdispen);
         prev_col = int'(col);
      end
   endtask

   task automatic run_lines(input int n, input int budget, input bit rnd);
      int target, k;
      target = ls_seen + n;
      k = 0;
      while (ls_seen < target && k < budget) begin
         cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         k++;
      end
      check("lines_reached", 32'(ls_seen), 32'(target));
   endtask

   task automatic run_until(input int c, input int p, input int budget);
      int k;
      k = 0;
      while (!(int'(col) == c && (p < 0 || int'(pixel) == p)) && k < budget) begin
         cycle(1'b1);
         k++;
      end
      check("position_reached", 32'(col), 32'(c));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0;
      reg_ht = 8'd126; reg_hd = 8'd80; reg_hp = 8'd102; reg_hw = 4'd9; reg_cth = 4'd7;
      reg_atr = 1'b0; reg_dbl = 1'b0; reg_ai = 8'd0; reg_deb = 8'd125; reg_dee = 8'd100;
      model_reset();
      @(negedge clk); @(negedge clk);
      check("reset_state", 32'(dut_obs()), 32'd0);
      reset = 1'b0;

      // Basic line: period, sync, blank, visible window, display enable
      run_lines(3, 4000, 1'b0);
      check("A_line_enables", 32'(ls_last - ls_prev), 32'd1016);
      check("A_hsync_len", 32'(last_hs), 32'd72);
      check("A_hblank_len", 32'(last_hb), 32'd144);
      check("A_visible_len", 32'(last_vis), 32'd640);
      check("A_dispen_len", 32'(last_den), 32'd816);

      // Double pixel width
      reg_dbl = 1'b1;
      run_lines(3, 4000, 1'b0);
      check("B_line_enables", 32'(ls_last - ls_prev), 32'd889);
      check("B_hblank_len", 32'(last_hb), 32'd63);
      check("B_hsync_len", 32'(last_hs), 32'd63);
      check("B_visible_len", 32'(last_vis), 32'd560);

      // Address increment trim, display enable begin beyond total, random enable gaps
      reg_dbl = 1'b0; reg_ai = 8'd1; reg_deb = 8'd200;
      run_lines(3, 6000, 1'b1);
      check("C_line_enables", 32'(ls_last - ls_prev), 32'd1016);
      check("C_visible_len", 32'(last_vis), 32'd632);
      check("C_dispen_len", 32'(last_den), 32'd1008);

      // Total register written mid-line
      reg_ai = 8'd0; reg_deb = 8'd125;
      run_until(100, -1, 1100);
      reg_ht = 8'd60;
      run_lines(1, 1200, 1'b0);
`ifdef VDC_REG_SHADOW_EN
      check("D_wrap_after_write", 32'(wrap_col), 32'd126);
`else
      check("D_wrap_after_write", 32'(wrap_col), 32'd100);
`endif
      run_lines(1, 1200, 1'b0);
      check("D_wrap_next_line", 32'(wrap_col), 32'd60);

      // Asynchronous reset mid-line
      reg_ht = 8'd126;
      run_until(50, 3, 2000);
      check("E_pixel_before_reset", 32'(pixel), 32'd3);
      #2 reset = 1'b1;
      model_reset();
      #1 check("E_async_reset", 32'(dut_obs()), 32'd0);
      @(negedge clk); @(negedge clk);
      check("E_reset_held", 32'(dut_obs()), 32'd0);
      reset = 1'b0;
      cycle(1'b1);
`ifdef VDC_REG_SHADOW_EN
      check("E_first_enable", 32'({col, 3'b000, pixel}), 32'({8'd0, 3'b000, 5'd0}));
`else
      check("E_first_enable", 32'({col, 3'b000, pixel}), 32'({8'd0, 3'b000, 5'd1}));
`endif
      for (int i = 0; i < 40; i++) cycle(1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
